screen_dump: RTL and testbench

//  Reads the text VRAM in raster order and emits every cell as a byte stream on a

---
 rtl/screen_dump.sv | 131 +++++++++++++
 tb/tb_screen_dump.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/screen_dump.sv
// screen_dump: streams the text VRAM out in raster order over a valid/ready source port,
// optionally mapping control bytes to '.' and appending CR LF after every row.
module screen_dump #(
    parameter int LAST_COL = 59,
    parameter int LAST_ROW = 16,
    parameter bit EOL_EN   = 1'b1,
    parameter bit SANITIZE = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    output logic        o_running,
    output logic        o_done,
    output logic [7:0]  o_char,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [10:0] o_vram_addr,
    output logic        o_vram_ce,
    output logic        o_vram_wre,
    input  logic [7:0]  i_vram_dout
);
    localparam logic [5:0] COL_MAX = 6'(LAST_COL);
    localparam logic [4:0] ROW_MAX = 5'(LAST_ROW);

    typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, CR, LF, FIN} state_t;

    state_t     state, state_nxt;
    logic [4:0] row, row_nxt;
    logic [5:0] col, col_nxt;
    logic [7:0] char_nxt;
    logic       valid_nxt;
    logic [7:0] mapped;

    always_comb begin
        mapped = i_vram_dout;
        if (SANITIZE && ((i_vram_dout < 8'h20) || (i_vram_dout == 8'h7F)))
            mapped = 8'h2E;
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        char_nxt  = o_char;
        valid_nxt = o_valid;
        case (state)
            IDLE: begin
                if (i_start) begin
                    row_nxt   = 5'd0;
                    col_nxt   = 6'd0;
                    state_nxt = READ;
                end
            end
            READ:  state_nxt = LATCH;
            LATCH: begin
                char_nxt  = mapped;
                valid_nxt = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (i_ready) begin
                    valid_nxt = 1'b0;
                    if (col < COL_MAX) begin
                        col_nxt   = col + 6'd1;
                        state_nxt = READ;
                    end else begin
                        col_nxt = 6'd0;
                        if (EOL_EN) begin
                            char_nxt  = 8'h0D;
                            valid_nxt = 1'b1;
                            state_nxt = CR;
                        end else if (row < ROW_MAX) begin
                            row_nxt   = row + 5'd1;
                            state_nxt = READ;
                        end else begin
                            state_nxt = FIN;
                        end
                    end
                end
            end
            // CR and LF are back-to-back, so o_valid stays high between them
            CR: begin
                if (i_ready) begin
                    char_nxt  = 8'h0A;
                    state_nxt = LF;
                end
            end
            LF: begin
                if (i_ready) begin
                    valid_nxt = 1'b0;
                    if (row < ROW_MAX) begin
                        row_nxt   = row + 5'd1;
                        state_nxt = READ;
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            FIN: begin
                row_nxt   = 5'd0;
                col_nxt   = 6'd0;
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state   <= IDLE;
            row     <= 5'd0;
            col     <= 6'd0;
            o_char  <= 8'h00;
            o_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            row     <= row_nxt;
            col     <= col_nxt;
            o_char  <= char_nxt;
            o_valid <= valid_nxt;
        end
    end

    assign o_running   = (state != IDLE) && (state != FIN);
    assign o_done      = (state == FIN);
    assign o_vram_ce   = (state == READ);
    assign o_vram_wre  = 1'b0;
    assign o_vram_addr = {row, col};

endmodule

// File: tb/tb_screen_dump.sv
// tb_screen_dump: drives two screen_dump instances (raw with CR LF, sanitised without)
// from bench-side VRAM models and compares every accepted byte with a raster-order model.
module tb_screen_dump;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        ready;
    bit          sel;

    logic        running1, done1, valid1, ce1, wre1;
    logic [7:0]  char1, dout1;
    logic [10:0] addr1;
    logic        running2, done2, valid2, ce2, wre2;
    logic [7:0]  char2, dout2;
    logic [10:0] addr2;

    logic        start1, start2, ready1, ready2;
    logic        cur_valid, cur_done, cur_running, cur_ce, cur_wre;
    logic [7:0]  cur_char;
    logic [10:0] cur_addr;

    logic [7:0]  mem1 [2048];
    logic [7:0]  mem2 [2048];
    logic [7:0]  rx   [2048];
    logic [7:0]  exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    screen_dump #(.LAST_COL(59), .LAST_ROW(16), .EOL_EN(1'b1), .SANITIZE(1'b0)) dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start1), .o_running(running1),
        .o_done(done1), .o_char(char1), .o_valid(valid1), .i_ready(ready1),
        .o_vram_addr(addr1), .o_vram_ce(ce1), .o_vram_wre(wre1), .i_vram_dout(dout1)
    );

    screen_dump #(.LAST_COL(59), .LAST_ROW(16), .EOL_EN(1'b0), .SANITIZE(1'b1)) dut2 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start2), .o_running(running2),
        .o_done(done2), .o_char(char2), .o_valid(valid2), .i_ready(ready2),
        .o_vram_addr(addr2), .o_vram_ce(ce2), .o_vram_wre(wre2), .i_vram_dout(dout2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read VRAM models, one per instance
    always @(posedge clk) begin
        if (ce1) dout1 <= mem1[addr1];
        if (ce2) dout2 <= mem2[addr2];
    end

    assign start1      = sel ? 1'b0 : start;
    assign start2      = sel ? start : 1'b0;
    assign ready1      = sel ? 1'b0 : ready;
    assign ready2      = sel ? ready : 1'b0;
    assign cur_valid   = sel ? valid2   : valid1;
    assign cur_done    = sel ? done2    : done1;
    assign cur_running = sel ? running2 : running1;
    assign cur_ce      = sel ? ce2      : ce1;
    assign cur_wre     = sel ? wre2     : wre1;
    assign cur_char    = sel ? char2    : char1;
    assign cur_addr    = sel ? addr2    : addr1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Expected stream: every cell in raster order, then the row terminator if enabled
    task automatic buildExpected();
        logic [7:0] b;
        bit san, eol;
        san = sel;
        eol = !sel;
        exp_q.delete();
        for (int r = 0; r <= 16; r++) begin
            for (int c = 0; c <= 59; c++) begin
                b = sel ? mem2[r * 64 + c] : mem1[r * 64 + c];
                if (san && (b < 8'h20 || b == 8'h7F)) b = 8'h2E;
                exp_q.push_back(b);
            end
            if (eol) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
    endtask

    task automatic applyStimulus(input int ready_pct, input bit restart_mid,
                                 input int abort_at, output int n_rx);
        int idx, cyc, first_valid, extra_done;
        bit prev_stall, got_done;
        logic [7:0] prev_char;
        buildExpected();
        idx = 0; cyc = 0; first_valid = -1; prev_stall = 0; got_done = 0;
        prev_char = 8'h00;
        @(negedge clk);
        start = 1'b1;
        ready = 1'b0;
        while (cyc < 20000 && !got_done) begin
            @(negedge clk);
            cyc++;
            start = (restart_mid && cyc == 200) ? 1'b1 : 1'b0;
            if (abort_at >= 0 && idx >= abort_at) begin
                rstn  = 1'b0;
                ready = 1'b0;
                start = 1'b0;
                @(negedge clk);
                checkOutput("abort_valid", {31'b0, cur_valid}, 32'd0);
                checkOutput("abort_running", {31'b0, cur_running}, 32'd0);
                checkOutput("abort_ce", {31'b0, cur_ce}, 32'd0);
                checkOutput("abort_done", {31'b0, cur_done}, 32'd0);
                checkOutput("abort_char", {24'b0, cur_char}, 32'h00);
                rstn = 1'b1;
                n_rx = idx;
                return;
            end
            if (cur_valid && first_valid < 0) begin
                first_valid = cyc;
                checkOutput("latency", first_valid, 32'd3);
            end
            if (prev_stall) begin
                checkOutput("hold_valid", {31'b0, cur_valid}, 32'd1);
                checkOutput("hold_char", {24'b0, cur_char}, {24'b0, prev_char});
            end
            if (cur_ce)
                checkOutput("addr_col_range", {31'b0, (cur_addr[5:0] <= 6'd59)}, 32'd1);
            checkOutput("wre_low", {31'b0, cur_wre}, 32'd0);
            if (cur_done) begin
                got_done = 1'b1;
                checkOutput("running_at_done", {31'b0, cur_running}, 32'd0);
                checkOutput("byte_count", idx, exp_q.size());
            end else begin
                ready = ($urandom_range(0, 99) < ready_pct) ? 1'b1 : 1'b0;
                if (cur_valid && ready) begin
                    if (idx < exp_q.size()) begin
                        checkOutput($sformatf("byte[%0d]", idx), {24'b0, cur_char},
                                    {24'b0, exp_q[idx]});
                        rx[idx] = cur_char;
                    end else begin
                        checkOutput("extra_byte", idx + 1, exp_q.size());
                    end
                    idx++;
                end
                prev_stall = cur_valid && !ready;
                prev_char  = cur_char;
            end
        end
        checkOutput("done_seen", {31'b0, got_done}, 32'd1);
        ready = 1'b0;
        extra_done = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (cur_done || cur_running) extra_done++;
        end
        checkOutput("quiet_after_done", extra_done, 32'd0);
        n_rx = idx;
    endtask

    initial begin
        int n;
        rstn  = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        sel   = 1'b0;
        for (int a = 0; a < 2048; a++) begin
            mem1[a] = a[7:0];
            mem2[a] = 8'($urandom_range(0, 255));
        end
        mem2[5 * 64 + 10] = 8'h07;
        mem2[5 * 64 + 11] = 8'h7F;
        mem2[5 * 64 + 12] = 8'h41;

        repeat (3) @(negedge clk);
        checkOutput("rst_valid", {31'b0, valid1}, 32'd0);
        checkOutput("rst_running", {31'b0, running1}, 32'd0);
        checkOutput("rst_done", {31'b0, done1}, 32'd0);
        checkOutput("rst_char", {24'b0, char1}, 32'h00);
        checkOutput("rst_ce", {31'b0, ce1}, 32'd0);
        checkOutput("rst_wre", {31'b0, wre1}, 32'd0);
        checkOutput("rst_addr", {21'b0, addr1}, 32'd0);
        checkOutput("rst_valid2", {31'b0, valid2}, 32'd0);
        checkOutput("rst_running2", {31'b0, running2}, 32'd0);
        rstn = 1'b1;

        $display("[TB] full dump, sink always ready");
        applyStimulus(100, 1'b0, -1, n);
        checkOutput("count_eol", n, 32'd1054);
        checkOutput("first_byte", {24'b0, rx[0]}, 32'h00);
        checkOutput("row0_last", {24'b0, rx[59]}, 32'h3B);
        checkOutput("row0_cr", {24'b0, rx[60]}, 32'h0D);
        checkOutput("row0_lf", {24'b0, rx[61]}, 32'h0A);
        checkOutput("final_byte", {24'b0, rx[1053]}, 32'h0A);

        $display("[TB] backpressure with start re-pulsed mid-dump");
        applyStimulus(30, 1'b1, -1, n);
        checkOutput("count_backpressure", n, 32'd1054);

        $display("[TB] reset during row 8, then restart");
        applyStimulus(60, 1'b0, 8 * 62 + 5, n);
        applyStimulus(100, 1'b0, -1, n);
        checkOutput("count_after_abort", n, 32'd1054);
        checkOutput("restart_first", {24'b0, rx[0]}, 32'h00);

        $display("[TB] sanitised dump without row terminators");
        sel = 1'b1;
        applyStimulus(50, 1'b0, -1, n);
        checkOutput("count_no_eol", n, 32'd1020);
        checkOutput("bel_sanitised", {24'b0, rx[310]}, 32'h2E);
        checkOutput("del_sanitised", {24'b0, rx[311]}, 32'h2E);
        checkOutput("letter_raw", {24'b0, rx[312]}, 32'h41);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
